io_byte_bus_scheduler: RTL
==========================

Name: io_byte_bus_scheduler

Overview:
- Shares the 8-bit TinyTapeout pin interface between two 32-bit requesters: instruction fetch (if_*) and data memory (dm_*).
- Grants one requester at a time. Serialises its address, and its write data on stores, into byte beats. Reassembles read words from data_input.
- Sits between the MIPS core's fetch/load-store ports and the chip pins.
- Replaces ad-hoc per-phase sequencing with a single request/ack handshake per word.

Parameters:
- TURN_CYCLES, default 1: bus turnaround cycles between the last address beat and the first read beat of a read. Legal range 1..7.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; held high with if_addr stable until if_ack.
- if_addr  in  32  fetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  32  fetched instruction; held until the next fetch completes.
- dm_req  in  1  data request; held high with dm_we/dm_addr/dm_wdata stable until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_ack  out  1  one-cycle completion pulse.
- dm_rdata  out  32  load data; held until the next load completes.
- data_input  in  8  byte from pins.
- address_out  out  8  address byte to pins.
- data_output  out  8  store data byte to pins.
- bus_phase  out  2  pin qualifier: 0 idle, 1 address beat, 2 turnaround, 3 read beat.
- bus_we  out  1  1 during address beats of a store.
- owner  out  1  current or last grantee: 0 fetch, 1 data.

Behaviour:
- States: IDLE, ADDR, TURN, READ, DONE. A 2-bit beat counter and a 3-bit turn counter are cleared on every state entry.
- Reset, asynchronous: state IDLE, all counters 0. address_out, data_output, bus_phase, bus_we, owner, if_ack, dm_ack, if_rdata, dm_rdata all 0. Round-robin pointer 0.
- Reset mid-transaction: abort immediately. No ack is issued and the partial read word is discarded.
- IDLE:
  - If any req is high, arbitrate (see below), latch the owner's address, write data and we, and go to ADDR.
  - Otherwise stay in IDLE with bus_phase=0 and address_out/data_output=0.
- ADDR, 4 beats k=0..3, LSB first:
  - address_out = addr[8k+7:8k], bus_phase=1.
  - Store: data_output = wdata[8k+7:8k] and bus_we=1. Load/fetch: data_output=0 and bus_we=0.
  - After beat 3: a store goes to DONE; a load or fetch goes to TURN.
- TURN: stay TURN_CYCLES cycles with bus_phase=2, address_out=8'hFF, data_output=0. Then go to READ.
- READ, 4 beats k=0..3:
  - bus_phase=3, address_out=0.
  - On each posedge, data_input is captured into shift byte k (LSB first).
  - After beat 3, go to DONE.
- DONE, 1 cycle:
  - Pulse the owner's ack.
  - For a read, the owner's rdata register is loaded with the assembled word, registered so it is visible in the same cycle as the ack.
  - The non-owner's rdata is unchanged.
  - Next state is IDLE. The minimum gap between transactions is one IDLE cycle.
- Latency, with IDLE sampling req at cycle 0:
  - Store: address beats in cycles 1..4, ack at cycle 5.
  - Read with TURN_CYCLES=1: ADDR 1..4, TURN 5, READ 6..9, ack at cycle 10.
  - Read, general: ack at cycle 9+TURN_CYCLES.
- The address and write data latched in IDLE are used for the whole transaction. Requester inputs changing mid-transaction have no effect.
- req deasserted mid-transaction: the transaction still completes and the ack still pulses.
- A req still high in the cycle after its ack starts a new transaction. The requester must drop req on ack to avoid a duplicate.
- Arbitration, default (fixed priority): if both req are high in IDLE, data wins. owner is updated at grant.
- dm_we is ignored for fetch; fetch is always a read.

Optional Feature:
- Macro: IO_SCHED_ROUND_ROBIN_EN.
- When defined: a 1-bit pointer flips to the non-granted side after each grant. On simultaneous requests, the side the pointer selects wins. A single requester always wins regardless of the pointer.
- When undefined: fixed priority, data over fetch. No pointer register exists.

Test Plan:
- Fetch only, if_addr=32'h0040_0010, data_input supplies 8'h20, 8'h08, 8'h01, 8'h8C in the read beats:
  - address_out = 10, 00, 40, 00 in cycles 1..4; TURN in cycle 5 with address_out=FF.
  - if_ack at cycle 10 with if_rdata=32'h8C01_0820.
- Store, dm_addr=32'h1000_0004, dm_wdata=32'hDEAD_BEEF:
  - beats address_out 04, 00, 00, 10 and data_output EF, BE, AD, DE, with bus_we=1.
  - dm_ack at cycle 5; no TURN or READ phase.
- Both req high in the same IDLE cycle, twice back-to-back:
  - Fixed priority: data is granted both times.
  - With IO_SCHED_ROUND_ROBIN_EN: data is granted first, then fetch.
- TURN_CYCLES=3 load: bus_phase=2 for exactly 3 cycles; dm_ack at cycle 12.
- Assert rst in cycle 7 of a load:
  - All outputs return to 0 asynchronously, with no dm_ack.
  - After release with req still high, the load restarts from address beat 0.
- dm_req dropped in cycle 2 of a store: the store completes and dm_ack pulses at cycle 5; the next cycle stays IDLE.

Source files
------------

// File: rtl/io_byte_bus_scheduler.sv
// io_byte_bus_scheduler
// Shares the 8-bit pin interface between instruction fetch (if_*) and data
// memory (dm_*). One requester is granted at a time. Its address, and its
// write data on stores, go out as four LSB-first byte beats. Read words are
// reassembled from four data_input beats that follow a turnaround.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   if_req/if_addr      fetch request (always a read)
//   if_ack/if_rdata     one-cycle completion pulse / fetched word (held)
//   dm_req/dm_we/...    data request: store when dm_we=1, load otherwise
//   dm_ack/dm_rdata     one-cycle completion pulse / load word (held)
//   data_input          read byte from the pins
//   address_out         address byte to the pins (8'hFF during turnaround)
//   data_output         store data byte to the pins
//   bus_phase           0 idle, 1 address beat, 2 turnaround, 3 read beat
//   bus_we              1 during the address beats of a store
//   owner               current or last grantee: 0 fetch, 1 data
//
// Build option: define IO_SCHED_ROUND_ROBIN_EN to replace fixed data-over-fetch
// priority with a 1-bit round-robin pointer.
module io_byte_bus_scheduler #(
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    input  logic [7:0]  data_input,
    output logic [7:0]  address_out,
    output logic [7:0]  data_output,
    output logic [1:0]  bus_phase,
    output logic        bus_we,
    output logic        owner
);

    localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_TURN,
        S_READ,
        S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  beat_cnt;
    logic [2:0]  turn_cnt;
    logic        we_q;
    logic [23:0] addr_sh;
    logic [23:0] wdata_sh;
    logic [23:0] rd_sh;

    logic        pick_dm_c;
    logic        store_c;
    logic [31:0] sel_addr_c;

    // Grant decision, only meaningful while IDLE sees a request
`ifdef IO_SCHED_ROUND_ROBIN_EN
    logic rr_q;  // 1 = fetch favoured on a tie
    assign pick_dm_c = dm_req & (~if_req | ~rr_q);
`else
    assign pick_dm_c = dm_req;
`endif

    assign store_c    = pick_dm_c & dm_we;
    assign sel_addr_c = pick_dm_c ? dm_addr : if_addr;

    // Transaction sequencer with registered pin and handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            beat_cnt    <= 2'd0;
            turn_cnt    <= 3'd0;
            we_q        <= 1'b0;
            addr_sh     <= 24'd0;
            wdata_sh    <= 24'd0;
            rd_sh       <= 24'd0;
            address_out <= 8'd0;
            data_output <= 8'd0;
            bus_phase   <= 2'd0;
            bus_we      <= 1'b0;
            owner       <= 1'b0;
            if_ack      <= 1'b0;
            dm_ack      <= 1'b0;
            if_rdata    <= 32'd0;
            dm_rdata    <= 32'd0;
`ifdef IO_SCHED_ROUND_ROBIN_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    beat_cnt <= 2'd0;
                    turn_cnt <= 3'd0;
                    if (if_req || dm_req) begin
                        state       <= S_ADDR;
                        owner       <= pick_dm_c;
                        we_q        <= store_c;
                        addr_sh     <= sel_addr_c[31:8];
                        wdata_sh    <= store_c ? dm_wdata[31:8] : 24'd0;
                        address_out <= sel_addr_c[7:0];
                        data_output <= store_c ? dm_wdata[7:0] : 8'd0;
                        bus_phase   <= 2'd1;
                        bus_we      <= store_c;
`ifdef IO_SCHED_ROUND_ROBIN_EN
                        rr_q        <= pick_dm_c;
`endif
                    end else begin
                        address_out <= 8'd0;
                        data_output <= 8'd0;
                        bus_phase   <= 2'd0;
                        bus_we      <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (beat_cnt == 2'd3) begin
                        beat_cnt    <= 2'd0;
                        turn_cnt    <= 3'd0;
                        data_output <= 8'd0;
                        bus_we      <= 1'b0;
                        if (we_q) begin
                            // Stores complete without a read phase
                            state       <= S_DONE;
                            dm_ack      <= 1'b1;
                            address_out <= 8'd0;
                            bus_phase   <= 2'd0;
                        end else begin
                            state       <= S_TURN;
                            address_out <= 8'hFF;
                            bus_phase   <= 2'd2;
                        end
                    end else begin
                        beat_cnt    <= beat_cnt + 2'd1;
                        address_out <= addr_sh[7:0];
                        data_output <= wdata_sh[7:0];
                        addr_sh     <= {8'd0, addr_sh[23:8]};
                        wdata_sh    <= {8'd0, wdata_sh[23:8]};
                    end
                end
                S_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state       <= S_READ;
                        beat_cnt    <= 2'd0;
                        turn_cnt    <= 3'd0;
                        address_out <= 8'd0;
                        bus_phase   <= 2'd3;
                    end else begin
                        turn_cnt <= turn_cnt + 3'd1;
                    end
                end
                S_READ: begin
                    rd_sh <= {data_input, rd_sh[23:8]};
                    if (beat_cnt == 2'd3) begin
                        // Final byte goes straight into rdata so it lines up with the ack
                        state     <= S_DONE;
                        beat_cnt  <= 2'd0;
                        turn_cnt  <= 3'd0;
                        bus_phase <= 2'd0;
                        if (owner) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= {data_input, rd_sh};
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= {data_input, rd_sh};
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    beat_cnt <= 2'd0;
                    turn_cnt <= 3'd0;
                end
                default: begin
                    state     <= S_IDLE;
                    beat_cnt  <= 2'd0;
                    turn_cnt  <= 3'd0;
                    bus_phase <= 2'd0;
                end
            endcase
        end
    end

endmodule
